// File: rtl/lsu_if.sv
// Pipeline request, data-bus and result signals of the load/store unit.
// slave = LSU side, master = pipeline/bus environment side.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        load_valid;
   logic [31:0] load_data;
   logic        busy;
   logic        bus_err;
   logic        misalign_exc;

   modport slave (
      input  req_valid, req_is_store, req_size, req_unsigned,
      input  req_addr, req_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata,
      output req_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output load_valid, load_data, busy, bus_err, misalign_exc
   );

   modport master (
      output req_valid, req_is_store, req_size, req_unsigned,
      output req_addr, req_wdata,
      output bus_gnt, bus_rvalid, bus_rdata,
      input  req_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  load_valid, load_data, busy, bus_err, misalign_exc
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit on a req/gnt/rvalid bus, one op at a time.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned ops instead of forcing alignment.
module load_store_unit #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic  clk,
   input logic  rst_n,
   lsu_if.slave lsu
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

   state_e            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
   logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic [15:0]       timer_q, timer_d;
   logic              load_valid_q, load_valid_d;
   logic [XLEN-1:0]   load_data_q, load_data_d;
   logic              bus_err_q, bus_err_d;
   logic              mis_exc_q, mis_exc_d;

   logic              mis;
   logic [1:0]        off_eff;
   logic [3:0]        be;
   logic [XLEN-1:0]   wd;
   logic [15:0]       sh;
   logic [XLEN-1:0]   ext;

   // Request decode: effective offset, byte enables, replicated store data
   always_comb begin
      off_eff = 2'b00;
      be      = 4'b1111;
      wd      = lsu.req_wdata;
      unique case (lsu.req_size)
         2'b00: begin
            off_eff = lsu.req_addr[1:0];
            be      = 4'b0001 << lsu.req_addr[1:0];
            wd      = {4{lsu.req_wdata[7:0]}};
         end
         2'b01: begin
            off_eff = {lsu.req_addr[1], 1'b0};
            be      = 4'b0011 << {lsu.req_addr[1], 1'b0};
            wd      = {2{lsu.req_wdata[15:0]}};
         end
         default: begin
            off_eff = 2'b00;
            be      = 4'b1111;
            wd      = lsu.req_wdata;
         end
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (lsu.req_size == 2'b01 && lsu.req_addr[0]) ||
            (lsu.req_size[1] && lsu.req_addr[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
   end

   // Load alignment and extension
   always_comb begin
      sh  = 16'(lsu.bus_rdata >> {off_q, 3'b000});
      ext = lsu.bus_rdata;
      unique case (size_q)
         2'b00:   ext = {{24{~uns_q & sh[7]}}, sh[7:0]};
         2'b01:   ext = {{16{~uns_q & sh[15]}}, sh[15:0]};
         default: ext = lsu.bus_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_be_d     = bus_be_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      timer_d      = timer_q;
      load_valid_d = 1'b0;
      load_data_d  = load_data_q;
      bus_err_d    = 1'b0;
      mis_exc_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (lsu.req_valid) begin
               if (mis) begin
                  mis_exc_d = 1'b1;
               end else begin
                  state_d     = REQ;
                  bus_req_d   = 1'b1;
                  bus_we_d    = lsu.req_is_store;
                  bus_addr_d  = {lsu.req_addr[31:2], 2'b00};
                  bus_wdata_d = wd;
                  bus_be_d    = be;
                  size_d      = lsu.req_size;
                  uns_d       = lsu.req_unsigned;
                  off_d       = off_eff;
               end
            end
         end
         REQ: begin
            if (lsu.bus_gnt) begin
               state_d   = WAIT;
               bus_req_d = 1'b0;
               timer_d   = '0;
            end
         end
         WAIT: begin
            if (lsu.bus_rvalid) begin
               state_d = IDLE;
               if (!bus_we_q) begin
                  load_valid_d = 1'b1;
                  load_data_d  = ext;
               end
            end else begin
               timer_d = timer_q + 16'd1;
               if (TIMEOUT_CYCLES != 0 && timer_d == TO) begin
                  state_d   = IDLE;
                  bus_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         bus_be_q     <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         off_q        <= '0;
         timer_q      <= '0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
         bus_err_q    <= 1'b0;
         mis_exc_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_be_q     <= bus_be_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         timer_q      <= timer_d;
         load_valid_q <= load_valid_d;
         load_data_q  <= load_data_d;
         bus_err_q    <= bus_err_d;
         mis_exc_q    <= mis_exc_d;
      end
   end

   assign lsu.req_ready    = (state_q == IDLE);
   assign lsu.busy         = (state_q != IDLE);
   assign lsu.bus_req      = bus_req_q;
   assign lsu.bus_we       = bus_we_q;
   assign lsu.bus_addr     = bus_addr_q;
   assign lsu.bus_wdata    = bus_wdata_q;
   assign lsu.bus_be       = bus_be_q;
   assign lsu.load_valid   = load_valid_q;
   assign lsu.load_data    = load_data_q;
   assign lsu.bus_err      = bus_err_q;
   assign lsu.misalign_exc = mis_exc_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, gnt stall,
// timeout, misalignment and reset in mid-transaction.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   lsu_if bus ();

   load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(255)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .lsu   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
      bus.req_valid    = 1'b1;
      bus.req_is_store = st;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      step();
      bus.req_valid    = 1'b0;
   endtask

   // Minimum-latency load: accept, gnt in first REQ cycle, rvalid next
   task automatic do_load(input string tag, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] rd, input logic [3:0] ebe,
                          input logic [31:0] edata);
      issue(1'b0, sz, uns, a, 32'h0);
      chk({tag, "_req"}, 32'(bus.bus_req), 32'd1);
      chk({tag, "_be"}, 32'(bus.bus_be), 32'(ebe));
      chk({tag, "_addr"}, bus.bus_addr, {a[31:2], 2'b00});
      bus.bus_gnt = 1'b1;
      step();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = rd;
      step();
      bus.bus_rvalid = 1'b0;
      chk({tag, "_lv"}, 32'(bus.load_valid), 32'd1);
      chk({tag, "_data"}, bus.load_data, edata);
   endtask

   initial begin
      int n;
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.bus_gnt      = 1'b0;
      bus.bus_rvalid   = 1'b0;
      bus.bus_rdata    = '0;
      step();
      step();
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_req", 32'(bus.bus_req), 32'd0);
      chk("rst_be", 32'(bus.bus_be), 32'd0);
      chk("rst_ldata", bus.load_data, 32'd0);
      rst_n = 1'b1;
      step();

      // 1: LB 0x1003, minimum latency
      issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
      chk("lb_req", 32'(bus.bus_req), 32'd1);
      chk("lb_be", 32'(bus.bus_be), 32'h8);
      chk("lb_addr", bus.bus_addr, 32'h0000_1000);
      chk("lb_we", 32'(bus.bus_we), 32'd0);
      chk("lb_busy", 32'(bus.busy), 32'd1);
      chk("lb_ready", 32'(bus.req_ready), 32'd0);
      bus.bus_gnt = 1'b1;
      step();
      bus.bus_gnt = 1'b0;
      chk("lb_req_drop", 32'(bus.bus_req), 32'd0);
      chk("lb_lv_c2", 32'(bus.load_valid), 32'd0);
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'h8011_2233;
      step();
      bus.bus_rvalid = 1'b0;
      chk("lb_lv_c3", 32'(bus.load_valid), 32'd1);
      chk("lb_data", bus.load_data, 32'hFFFF_FF80);
      chk("lb_idle", 32'(bus.busy), 32'd0);
      chk("lb_mis", 32'(bus.misalign_exc), 32'd0);
      step();
      chk("lb_lv_pulse", 32'(bus.load_valid), 32'd0);
      chk("lb_hold", bus.load_data, 32'hFFFF_FF80);

      // 2: LHU 0x2002; rvalid alongside gnt must be ignored
      issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
      chk("lhu_be", 32'(bus.bus_be), 32'hC);
      bus.bus_gnt    = 1'b1;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'hDEAD_DEAD;
      step();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b0;
      step();
      chk("lhu_early_lv", 32'(bus.load_valid), 32'd0);
      chk("lhu_wait_busy", 32'(bus.busy), 32'd1);
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'hBEEF_1234;
      step();
      bus.bus_rvalid = 1'b0;
      chk("lhu_lv", 32'(bus.load_valid), 32'd1);
      chk("lhu_data", bus.load_data, 32'h0000_BEEF);

      // 3: SB 0x3001 with gnt held off for 3 cycles
      issue(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'hAABB_CCDD);
      for (int i = 0; i < 3; i++) begin
         chk("sb_req_hold", 32'(bus.bus_req), 32'd1);
         step();
      end
      chk("sb_req_4th", 32'(bus.bus_req), 32'd1);
      chk("sb_be", 32'(bus.bus_be), 32'h2);
      chk("sb_wdata", bus.bus_wdata, 32'hDDDD_DDDD);
      chk("sb_we", 32'(bus.bus_we), 32'd1);
      bus.bus_gnt = 1'b1;
      step();
      bus.bus_gnt = 1'b0;
      chk("sb_req_drop", 32'(bus.bus_req), 32'd0);
      bus.bus_rvalid = 1'b1;
      step();
      bus.bus_rvalid = 1'b0;
      chk("sb_no_lv", 32'(bus.load_valid), 32'd0);
      chk("sb_idle", 32'(bus.busy), 32'd0);
      chk("sb_ldata_kept", bus.load_data, 32'h0000_BEEF);

      // Half store replication and signed half load
      issue(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h1122_3344);
      chk("sh_be", 32'(bus.bus_be), 32'hC);
      chk("sh_wdata", bus.bus_wdata, 32'h3344_3344);
      bus.bus_gnt = 1'b1;
      step();
      bus.bus_gnt    = 1'b0;
      bus.bus_rvalid = 1'b1;
      step();
      bus.bus_rvalid = 1'b0;
      do_load("lh", 2'b01, 1'b0, 32'h0000_5000, 32'h1234_8001,
              4'h3, 32'hFFFF_8001);
      do_load("lbu", 2'b00, 1'b1, 32'h0000_5001, 32'h0000_9A00,
              4'h2, 32'h0000_009A);

      // 4: LW timeout
      issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
      bus.bus_gnt = 1'b1;
      step();
      bus.bus_gnt = 1'b0;
      n = 0;
      while (!bus.bus_err && n < 400) begin
         step();
         n++;
      end
      chk("to_cycles", n, 32'd255);
      chk("to_busy", 32'(bus.busy), 32'd0);
      chk("to_ready", 32'(bus.req_ready), 32'd1);
      chk("to_no_lv", 32'(bus.load_valid), 32'd0);
      step();
      chk("to_pulse", 32'(bus.bus_err), 32'd0);

      // 5: LW at misaligned address 0x4002
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0);
      chk("mis_exc", 32'(bus.misalign_exc), 32'd1);
      chk("mis_no_req", 32'(bus.bus_req), 32'd0);
      chk("mis_busy", 32'(bus.busy), 32'd0);
      step();
      chk("mis_pulse", 32'(bus.misalign_exc), 32'd0);
      chk("mis_no_lv", 32'(bus.load_valid), 32'd0);
`else
      do_load("lw_mis", 2'b10, 1'b0, 32'h0000_4002, 32'hCAFE_F00D,
              4'hF, 32'hCAFE_F00D);
      chk("lw_mis_exc", 32'(bus.misalign_exc), 32'd0);
`endif

      // 6: reset while in WAIT, then late rvalid
      issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0);
      bus.bus_gnt = 1'b1;
      step();
      bus.bus_gnt = 1'b0;
      chk("rw_busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rw_busy", 32'(bus.busy), 32'd0);
      chk("rw_ready", 32'(bus.req_ready), 32'd1);
      chk("rw_addr", bus.bus_addr, 32'd0);
      chk("rw_be", 32'(bus.bus_be), 32'd0);
      chk("rw_ldata", bus.load_data, 32'd0);
      step();
      rst_n          = 1'b1;
      bus.bus_rvalid = 1'b1;
      bus.bus_rdata  = 32'h5555_5555;
      step();
      bus.bus_rvalid = 1'b0;
      step();
      chk("rw_late_lv", 32'(bus.load_valid), 32'd0);
      chk("rw_late_data", bus.load_data, 32'd0);
      chk("rw_late_busy", 32'(bus.busy), 32'd0);
      do_load("rw_next", 2'b10, 1'b0, 32'h0000_8000, 32'h0BAD_F00D,
              4'hF, 32'h0BAD_F00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
